// File: rtl/parallel_lfsr_checker_pkg.sv
// parallel_lfsr_checker_pkg: shared state encoding and Fibonacci LFSR step functions
//   lfsr_next    : one step, next(s) = {s[n-2:0], ^(s & p)} on the low n bits
//   lfsr_advance : k successive steps from a seed
package parallel_lfsr_checker_pkg;
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_e;
  localparam int MAX_N = 64;
  typedef logic [MAX_N-1:0] word_t;
  function automatic word_t lfsr_next(input word_t s, input word_t p, input int n);
    word_t m;
    m = (n >= MAX_N) ? '1 : ((word_t'(1) << n) - word_t'(1));
    return ((s << 1) | word_t'(^(s & p & m))) & m;
  endfunction
  function automatic word_t lfsr_advance(input word_t s, input word_t p, input int n, input int k);
    word_t r;
    r = s;
    for (int i = 0; i < k; i++) r = lfsr_next(r, p, n);
    return r;
  endfunction
endpackage

// File: rtl/parallel_lfsr_checker_lfsr_beat_expand.sv
// lfsr_beat_expand: combinational expansion of a seed into one beat of M words
//   seed_i      : state of word 0
//   words_o     : word k = next^k(seed_i) at bits [(k+1)*N-1 : k*N]
//   next_seed_o : next^M(seed_i), word 0 of the following beat
module lfsr_beat_expand
  import parallel_lfsr_checker_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4,
  parameter logic [N-1:0] P = 'h8E
) (
  input  logic [N-1:0]   seed_i,
  output logic [M*N-1:0] words_o,
  output logic [N-1:0]   next_seed_o
);
  always_comb begin
    for (int k = 0; k < M; k++) words_o[k*N +: N] = N'(lfsr_advance(word_t'(seed_i), word_t'(P), N, k));
    next_seed_o = N'(lfsr_advance(word_t'(seed_i), word_t'(P), N, M));
  end
endmodule

// File: rtl/parallel_lfsr_checker.sv
// parallel_lfsr_checker: self-synchronising checker for a parallel Fibonacci PRBS stream
//   i_clk, i_rst_n : clock, async active-low reset
//   i_valid/i_data : beat qualifier and M words of N bits
//   i_clr_cnt      : synchronous clear of the error counter
//   o_locked, o_state, o_err_mask, o_err_cnt : registered status
module parallel_lfsr_checker
  import parallel_lfsr_checker_pkg::*;
#(
  parameter int LFSR_N = 8,
  parameter int LFSR_M = 4,
  parameter logic [LFSR_N-1:0] LFSR_P = 'h8E,
  parameter int LOCK_CNT = 2,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [LFSR_M*LFSR_N-1:0] i_data,
  input  logic                     i_clr_cnt,
  output logic                     o_locked,
  output logic [1:0]               o_state,
  output logic [LFSR_M-1:0]        o_err_mask,
  output logic [CNT_W-1:0]         o_err_cnt
);
  localparam int N = LFSR_N;
  localparam int M = LFSR_M;
  localparam int RC_MAX = LOCK_CNT > UNLOCK_CNT ? LOCK_CNT : UNLOCK_CNT;
  localparam int RW = $clog2(RC_MAX + 1);
  localparam int PW = $clog2(M + 1);
  state_e state_q, state_d;
  logic [N-1:0] exp_q, exp_d, exp_next, reseed;
  logic [M*N-1:0] exp_words;
  logic [RW-1:0] good_q, good_d, bad_q, bad_d, good_inc, bad_inc;
  logic [M-1:0] mask_q, mask_d, mism;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
  logic [CNT_W:0] sum;
  logic [PW-1:0] pop;
  logic last_nz;
  lfsr_beat_expand #(.N(N), .M(M), .P(LFSR_P)) u_expand (
    .seed_i(exp_q), .words_o(exp_words), .next_seed_o(exp_next)
  );
  always_comb begin
    mism = '0;
    pop = '0;
    for (int k = 0; k < M; k++) begin
      mism[k] = i_data[k*N +: N] != exp_words[k*N +: N];
      pop = pop + PW'(i_data[k*N +: N] != exp_words[k*N +: N]);
    end
  end
  assign last_nz  = |i_data[(M-1)*N +: N];
  assign reseed   = N'(lfsr_next(word_t'(i_data[(M-1)*N +: N]), word_t'(LFSR_P), N));
  assign good_inc = good_q + RW'(1);
  assign bad_inc  = bad_q + RW'(1);
  assign sum      = {1'b0, cnt_q} + (CNT_W+1)'(pop);
  assign cnt_sat  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    good_d  = good_q;
    bad_d   = bad_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    if (i_valid) begin
      case (state_q)
        HUNT: if (last_nz) begin
          state_d = VERIFY;
          exp_d   = reseed;
          good_d  = '0;
        end
        VERIFY: begin
          mask_d = mism;
          if (mism == '0) begin
            good_d = good_inc;
            exp_d  = exp_next;
            if (good_inc == RW'(LOCK_CNT)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else if (last_nz) begin
            exp_d  = reseed;
            good_d = '0;
          end else begin
            state_d = HUNT;
            mask_d  = '0;
          end
        end
        LOCKED: begin
          mask_d = mism;
          exp_d  = exp_next;
          cnt_d  = cnt_sat;
          bad_d  = (mism == '0) ? '0 : bad_inc;
          if (mism != '0 && bad_inc == RW'(UNLOCK_CNT)) begin
            state_d = HUNT;
            mask_d  = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (i_clr_cnt) cnt_d = '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= HUNT;
      exp_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end
  assign o_locked   = state_q == LOCKED;
  assign o_state    = state_q;
  assign o_err_mask = mask_q;
  assign o_err_cnt  = cnt_q;
endmodule
